// File: rtl/intdiv_otfc.sv
// On-the-fly SD2 -> two's complement quotient conversion with final sign correction.
// Latency: N+2 cycles start->quo_valid with back-to-back digits; each stall adds one.
// Backpressure: none; stalls when dig_valid/fix_valid are low, never times out.
module intdiv_otfc #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dig_valid,
    input  logic [1:0]   dig,
    input  logic         fix_valid,
    input  logic [1:0]   fix_sign,
    output logic         busy,
    output logic         quo_valid,
    output logic [N:0]   quo
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CONV, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [N:0]      q, qm, q_nxt, qm_nxt, quo_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        qm_nxt    = qm;
        cnt_nxt   = cnt;
        quo_nxt   = quo;
        case (state)
            IDLE, DONE: begin
                state_nxt = (state == DONE) ? IDLE : state;
                if (start) begin
                    q_nxt     = '0;
                    qm_nxt    = '1;
                    cnt_nxt   = '0;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (dig_valid) begin
                    // Both candidates are built by appending a bit: no carry chain.
                    case (dig)
                        2'b10: begin
                            q_nxt  = {q[N-1:0], 1'b1};
                            qm_nxt = {q[N-1:0], 1'b0};
                        end
                        2'b01: begin
                            q_nxt  = {qm[N-1:0], 1'b1};
                            qm_nxt = {qm[N-1:0], 1'b0};
                        end
                        default: begin
                            q_nxt  = {q[N-1:0], 1'b0};
                            qm_nxt = {qm[N-1:0], 1'b1};
                        end
                    endcase
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CW'(N - 1)) state_nxt = FIX;
                end
            end
            FIX: begin
                if (fix_valid) begin
                    quo_nxt   = (fix_sign == 2'b01) ? qm : q;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            q         <= '0;
            qm        <= '0;
            cnt       <= '0;
            quo       <= '0;
            busy      <= 1'b0;
            quo_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            q         <= q_nxt;
            qm        <= qm_nxt;
            cnt       <= cnt_nxt;
            quo       <= quo_nxt;
            // Decoded from next state so the outputs come straight from flops.
            busy      <= (state_nxt == CONV) || (state_nxt == FIX);
            quo_valid <= (state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_intdiv_otfc.sv
// Randomized and directed scoreboard bench for intdiv_otfc (N=4).
module tb_intdiv_otfc;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst, start, dig_valid, fix_valid;
    logic [1:0]   dig, fix_sign;
    logic         busy, quo_valid;
    logic [N:0]   quo;

    intdiv_otfc #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .dig_valid(dig_valid), .dig(dig),
        .fix_valid(fix_valid), .fix_sign(fix_sign), .busy(busy),
        .quo_valid(quo_valid), .quo(quo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N:0] quo;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    // Reference: value of the signed-digit string, minus one ulp when the sign digit is -1.
    function automatic logic [N:0] model(input logic [1:0] d [N], input logic [1:0] fs);
        int v = 0;
        for (int i = 0; i < N; i++) begin
            v = 2 * v;
            if (d[i] == 2'b10) v = v + 1;
            else if (d[i] == 2'b01) v = v - 1;
        end
        if (fs == 2'b01) v = v - 1;
        return (N+1)'(v);
    endfunction

    always @(negedge clk) begin
        if (!rst && quo_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_quo_valid", 64'(quo_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quo", 64'(quo), 64'(e.quo));
                chk("quo_valid_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_in_done", 64'(busy), 64'd0);
            end
        end
    end

    // Called #1 after an edge; returns #1 after the edge that sampled fix_valid (DONE cycle).
    task automatic do_div(input logic [1:0] d [N], input logic [1:0] fs,
                          input int stall_pos, input int stall_n,
                          input int fix_stall, input bit abuse);
        exp_t e;
        e.quo = model(d, fs);
        e.cyc = cyc + N + 2 + stall_n + fix_stall;
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < N; i++) begin
            if (i == stall_pos) begin
                repeat (stall_n) begin
                    dig_valid = 1'b0;
                    dig       = 2'($urandom_range(0, 3));
                    if (abuse) begin
                        start     = 1'b1;
                        fix_valid = 1'b1;
                        fix_sign  = 2'($urandom_range(0, 3));
                    end
                    @(posedge clk); #1;
                    start     = 1'b0;
                    fix_valid = 1'b0;
                end
            end
            dig_valid = 1'b1;
            dig       = d[i];
            if (abuse && i == N - 1) begin
                fix_valid = 1'b1;
                fix_sign  = (fs == 2'b01) ? 2'b10 : 2'b01;
            end
            @(posedge clk); #1;
            fix_valid = 1'b0;
        end
        dig_valid = 1'b0;
        repeat (fix_stall) begin
            if (abuse) begin
                dig_valid = 1'b1;
                dig       = 2'($urandom_range(0, 3));
            end
            @(posedge clk); #1;
            dig_valid = 1'b0;
        end
        fix_valid = 1'b1;
        fix_sign  = fs;
        @(posedge clk); #1;
        fix_valid = 1'b0;
    endtask

    logic [1:0] dv [N];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; dig_valid = 1'b0; dig = 2'b00;
        fix_valid = 1'b0; fix_sign = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_quo_valid", 64'(quo_valid), 64'd0);
        chk("reset_quo", 64'(quo), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic, sign correction, negative quotients (chained back-to-back via DONE)
        dv = '{2'b10, 2'b00, 2'b01, 2'b10};
        do_div(dv, 2'b10, 0, 0, 0, 1'b0);
        do_div(dv, 2'b01, 0, 0, 0, 1'b0);
        dv = '{2'b01, 2'b01, 2'b01, 2'b01};
        do_div(dv, 2'b00, 0, 0, 0, 1'b0);
        do_div(dv, 2'b01, 0, 0, 0, 1'b0);
        // Zero codes, then with a 3-cycle mid-stream stall
        dv = '{2'b11, 2'b11, 2'b11, 2'b10};
        do_div(dv, 2'b11, 0, 0, 0, 1'b0);
        do_div(dv, 2'b11, 2, 3, 0, 1'b0);
        // Protocol abuse: start/fix_valid in CONV, dig_valid in FIX, early fix_valid
        dv = '{2'b10, 2'b00, 2'b01, 2'b10};
        do_div(dv, 2'b10, 1, 2, 2, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-conversion: partial result discarded, quo cleared
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dig_valid = 1'b1; dig = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        dig_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_quo", 64'(quo), 64'd0);
        chk("midreset_quo_valid", 64'(quo_valid), 64'd0);
        dv = '{2'b01, 2'b01, 2'b01, 2'b01};
        do_div(dv, 2'b00, 0, 0, 0, 1'b0);
        dv = '{2'b10, 2'b00, 2'b01, 2'b10};
        do_div(dv, 2'b01, 0, 0, 0, 1'b0);

        // Randomized divisions with stalls, idle gaps and ignored inputs
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) dv[i] = 2'($urandom_range(0, 3));
            do_div(dv, 2'($urandom_range(0, 3)), int'($urandom_range(0, N - 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)));
            repeat (int'($urandom_range(0, 2))) begin
                dig_valid = 1'($urandom_range(0, 1));
                fix_valid = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            dig_valid = 1'b0;
            fix_valid = 1'b0;
        end

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/intdiv_otfc.md
# intdiv_otfc

Downstream stage of the SD2 integer divider: accepts the quotient one radix-2 signed digit per cycle, MSB first, and converts it on the fly to two's complement. It keeps the running Q and QM = Q−1 registers (Ercegovac–Lang). After the last digit it takes the final sign digit from the overflow/sign stage (intdiv_ovf `sign_out`) and selects Q or Q−1 as the corrected quotient. There is no carry-propagate adder anywhere in the block.

## Interface
- `N`, default 16: number of quotient digits per division (N ≥ 2).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a new conversion; sampled in IDLE or DONE only.
- `dig_valid` in 1: `dig` holds a valid quotient digit this cycle.
- `dig` in 2: SD2 quotient digit, (p,n) encoding: 2'b10 = +1, 2'b01 = −1, 2'b00 = 0, 2'b11 = 0.
- `fix_valid` in 1: `fix_sign` is valid this cycle.
- `fix_sign` in 2: SD2 sign digit from intdiv_ovf `sign_out`, same encoding.
- `busy` out 1: high in CONV and FIX.
- `quo_valid` out 1: one-cycle pulse when `quo` is updated.
- `quo` out N+1: corrected quotient, two's complement.

## Operation
- States: IDLE, CONV, FIX, DONE. Digit counter `cnt` is ceil(log2(N+1)) bits.
- Internal registers: `q` and `qm`, each N+1 bits, all arithmetic modulo 2^(N+1).
- IDLE/DONE with `start`=1:
  - `q` ← 0; `qm` ← all ones (−1); `cnt` ← 0.
  - Next state is CONV.
- CONV with `dig_valid`=1: update both registers per digit, then `cnt` ← `cnt`+1:
  - +1: `q` ← 2q+1; `qm` ← 2q.
  - 0 (either code): `q` ← 2q; `qm` ← 2qm+1.
  - −1: `q` ← 2qm+1; `qm` ← 2qm.
- Invariant after every accepted digit: `qm` = `q`−1 (mod 2^(N+1)).
- When the N-th digit is accepted (`cnt`=N−1), next state is FIX.
- CONV with `dig_valid`=0: hold everything (stall, no timeout).
- FIX with `fix_valid`=1:
  - `quo` ← `qm` if `fix_sign` = −1 (2'b01); otherwise (+1, 2'b00, 2'b11) `quo` ← `q`.
  - Next state is DONE.
- FIX with `fix_valid`=0: hold.
- DONE: `quo_valid`=1 for exactly this cycle. Next state is IDLE, or CONV if `start`=1.
- `quo` holds its value until the next FIX update.
- Ignored inputs:
  - `start` in CONV/FIX.
  - `dig_valid` outside CONV.
  - `fix_valid` outside FIX.
  - `fix_valid` asserted in the same cycle as the N-th digit (it must arrive in FIX).
- Reset: state IDLE; `q`, `qm`, `cnt`, `quo` = 0; `busy` = 0; `quo_valid` = 0. Applies mid-conversion too; the partial result is discarded.

## Timing
- `start` sampled at edge 0 → CONV from cycle 1.
- With back-to-back digits, digits are sampled at edges 1..N and FIX is entered at cycle N+1.
- `fix_valid` sampled at edge N+1 → DONE at cycle N+2 with `quo`/`quo_valid`. Minimum latency is N+2 cycles from `start` to `quo_valid`.
- Each stalled cycle (`dig_valid`=0 in CONV, or `fix_valid`=0 in FIX) adds exactly one cycle.
- `busy` and `quo_valid` are registered state decodes, glitch-free and valid one cycle after the transition edge.
- Back-to-back divisions: `start` in the DONE cycle gives CONV the next cycle, with no IDLE bubble.

## Test plan
All tests use N=4.
- Basic positive: digits +1,0,−1,+1 (10,00,01,10) with fix_sign=2'b10 → `quo`=5'b00111 (7), `quo_valid` one cycle at cycle 6.
- Sign correction: same digits with fix_sign=2'b01 → `quo`=5'b00110 (6).
- Negative quotient: digits −1,−1,−1,−1 with fix_sign=2'b00 → `quo`=5'b10001 (−15); with fix_sign=2'b01 → 5'b10000 (−16).
- Zero codes and stalls:
  - Digits 11,11,11,10 → `quo`=5'b00001 for fix_sign=2'b11.
  - Insert 3 idle `dig_valid`=0 cycles mid-stream → same result, `quo_valid` 3 cycles later.
- Protocol abuse:
  - `start` pulsed during CONV → ignored, result unchanged.
  - `fix_valid` pulsed during CONV → ignored.
  - `dig_valid` in FIX → `q` unchanged.
- Reset mid-op: `rst` after 2 digits → IDLE, `busy`=0, `quo`=0; a fresh full sequence then yields the correct value; `start` in DONE chains without an IDLE cycle.
